ram_dp_arbiter: RTL and testbench
=================================

Name: ram_dp_arbiter

Overview:
Shares the two ports of the ram_dual_port block (8-bit data, 64 entries, write-enable per port, registered read) among NREQ requesters.
- Each cycle the block grants up to two requests, one on port A and one on port B, in round-robin order.
- It blocks same-address hazards between the two ports and counts them.
- It routes read data back to the requester that issued the read.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data width; matches RAM data_a/data_b
AW, 6, address width; matches RAM addr_a/addr_b

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous, active-low reset
req_valid  in  NREQ  request present, one bit per requester
req_we  in  NREQ  1 = write, 0 = read
req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_wdata  in  NREQ*DW  packed write data
req_ready  out  NREQ  grant; request accepted this cycle (combinational)
rsp_valid  out  NREQ  read data valid for requester i (registered)
rsp_rdata  out  NREQ*DW  packed read data; slice is 0 when its rsp_valid is 0
conflict_cnt  out  8  saturating count of deferred hazard requests
addr_a, data_a, we_a  out  AW, DW, 1  RAM port A drive
addr_b, data_b, we_b  out  AW, DW, 1  RAM port B drive
q_a, q_b  in  DW each  RAM read data, valid 1 cycle after address

Behaviour:
- Reset (rst_n=0 at posedge):
  - rr_ptr=0, response tags cleared, rsp_valid=0, conflict_cnt=0.
  - While rst_n=0, req_ready=0 and we_a=we_b=0, combinationally.
  - A read granted in the cycle before reset gets no response.
- Handshake: a requester holds req_valid and all its fields stable until req_ready is high. The transfer completes in the cycle where req_valid && req_ready.
- Arbitration (combinational):
  - Scan requesters starting at rr_ptr, wrapping modulo NREQ.
  - The first valid requester wins port A; the second wins port B.
- Hazard rule:
  - Applies when both ports have a winner, the addresses are equal, and at least one of the two is a write.
  - The port-B winner is not granted; port B stays idle that cycle.
  - conflict_cnt increments by 1 and saturates at 255.
  - Two reads to the same address are not a hazard; both are granted.
- Pointer update at posedge: rr_ptr <= (index of the last granted requester + 1) mod NREQ. If nothing is granted, rr_ptr is unchanged.
- RAM drive:
  - A granted port carries the winner's addr, wdata and we.
  - An idle port drives addr=0, data=0, we=0.
- Read return:
  - For each port, register {valid, requester id} when the port grants a read.
  - The next cycle, rsp_valid[id]=1 and rsp_rdata[id] = q of the port used.
  - Total latency is 1 cycle after grant.
  - Writes produce no response.
- Write-then-read: the RAM ordering holds. A read granted in the cycle after a write to the same address returns the new data.
- Single requester: it always takes port A; port B stays idle.

Decomposition:
- Package ram_arb_pkg holds:
  - DW/AW defaults;
  - typedef req_id_t (logic [2:0]);
  - typedef port_tag_t struct {valid, req_id_t id};
  - constant CNT_MAX=8'hFF.
- One sub-module, rr_pick2: a combinational round-robin finder.
  - Inputs: valid vector and rr_ptr.
  - Outputs: first/second winner indices and their found flags.
- All registers (rr_ptr, tags, counter) and the hazard logic stay in ram_dp_arbiter.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=0, we_a=we_b=0, rsp_valid=0, conflict_cnt=0.
2. Parallel writes: req0 writes 0x33@0x01 and req1 writes 0x44@0x02 in the same cycle -> both granted (A=req0, B=req1). Next cycle req2 reads 0x01 and req3 reads 0x02 -> one cycle later rsp_valid=4'b1100, rdata2=0x33, rdata3=0x44.
3. Hazard: rr_ptr=0, req0 writes 0x55@0x03 while req1 reads 0x03 -> only req0 granted, conflict_cnt=1. Next cycle req1 is granted on port A and gets rsp 0x55.
4. Fairness: all four requesters issue continuous reads at distinct addresses -> grant pairs (0,1),(2,3),(0,1)... Each requester is granted every 2 cycles; no starvation over 20 cycles.
5. Read-read same address: req2 and req3 both read 0x01 -> both granted, no count, both rdata=0x33.
6. Saturation and mid-operation reset:
   - 300 hazard cycles -> conflict_cnt=255.
   - rst_n=0 in the cycle after a read grant -> no rsp_valid pulse; conflict_cnt returns to 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the dual-port RAM arbiter.
package ram_arb_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 6;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  typedef logic [2:0] req_id_t;

  // One outstanding read per RAM port: which requester gets q next cycle.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } port_tag_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational round-robin finder: first and second valid requester,
// scanning upward from rr_ptr and wrapping modulo NREQ.
module rr_pick2
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] valid,
  input  req_id_t         rr_ptr,
  output req_id_t         first_idx,
  output logic            first_found,
  output req_id_t         second_idx,
  output logic            second_found
);

  logic [7:0] valid_ext;
  logic [3:0] sum;
  req_id_t    idx;

  // Walk NREQ positions from rr_ptr; the first two hits are the winners.
  always_comb begin
    valid_ext    = 8'(valid);
    first_idx    = '0;
    first_found  = 1'b0;
    second_idx   = '0;
    second_found = 1'b0;
    sum          = '0;
    idx          = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + 4'(k);
      if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
      idx = sum[2:0];
      if (valid_ext[idx]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = idx;
        end else if (!second_found) begin
          second_found = 1'b1;
          second_idx   = idx;
        end
      end
    end
  end

endmodule

// File: rtl/ram_dp_arbiter.sv
// Shares both ports of a registered-read dual-port RAM among NREQ requesters.
// Port A takes the first round-robin winner, port B the second; a same-address
// pair involving a write leaves port B idle and is counted.
//
// Handshake: a requester holds req_valid and its fields stable until
// req_ready; the transfer happens in the cycle where req_valid && req_ready.
module ram_dp_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_rdata,
  output logic [7:0]         conflict_cnt,
  output logic [AW-1:0]      addr_a,
  output logic [DW-1:0]      data_a,
  output logic               we_a,
  output logic [AW-1:0]      addr_b,
  output logic [DW-1:0]      data_b,
  output logic               we_b,
  input  logic [DW-1:0]      q_a,
  input  logic [DW-1:0]      q_b
);

  req_id_t   rr_ptr;
  port_tag_t tag_a, tag_b;

  req_id_t first_idx, second_idx;
  logic    first_found, second_found;

  logic [AW-1:0] addr_arr [8];
  logic [DW-1:0] wdata_arr [8];
  logic [7:0]    we_arr;

  logic    hazard, grant_a, grant_b;
  req_id_t last_idx;

  rr_pick2 #(.NREQ(NREQ)) u_pick (
    .valid        (req_valid),
    .rr_ptr       (rr_ptr),
    .first_idx    (first_idx),
    .first_found  (first_found),
    .second_idx   (second_idx),
    .second_found (second_found)
  );

  // Unpack requester fields into id-indexed arrays (unused slots read as 0).
  always_comb begin
    we_arr = '0;
    for (int i = 0; i < 8; i++) begin
      addr_arr[i]  = '0;
      wdata_arr[i] = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i]  = req_addr[i*AW +: AW];
      wdata_arr[i] = req_wdata[i*DW +: DW];
      we_arr[i]    = req_we[i];
    end
  end

  // Grants, hazard blocking and RAM port drive; nothing is granted in reset.
  always_comb begin
    hazard  = first_found && second_found &&
              (addr_arr[first_idx] == addr_arr[second_idx]) &&
              (we_arr[first_idx] || we_arr[second_idx]);
    grant_a = rst_n && first_found;
    grant_b = rst_n && second_found && !hazard;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (grant_a && (first_idx == 3'(i))) ||
                     (grant_b && (second_idx == 3'(i)));
    end
    addr_a   = grant_a ? addr_arr[first_idx]   : '0;
    data_a   = grant_a ? wdata_arr[first_idx]  : '0;
    we_a     = grant_a && we_arr[first_idx];
    addr_b   = grant_b ? addr_arr[second_idx]  : '0;
    data_b   = grant_b ? wdata_arr[second_idx] : '0;
    we_b     = grant_b && we_arr[second_idx];
    last_idx = grant_b ? second_idx : first_idx;
  end

  // Pointer, read tags and hazard counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      tag_a        <= '0;
      tag_b        <= '0;
      conflict_cnt <= '0;
    end else begin
      if (grant_a) begin
        rr_ptr <= (last_idx == req_id_t'(NREQ - 1)) ? '0 : last_idx + 3'd1;
      end
      tag_a.valid <= grant_a && !we_arr[first_idx];
      tag_a.id    <= first_idx;
      tag_b.valid <= grant_b && !we_arr[second_idx];
      tag_b.id    <= second_idx;
      if (rst_n && hazard && (conflict_cnt != CNT_MAX)) begin
        conflict_cnt <= conflict_cnt + 8'd1;
      end
    end
  end

  // Route q back to the reader. Gating with rst_n suppresses the response of
  // a read granted just before reset is asserted.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rst_n && tag_a.valid && (tag_a.id == 3'(i))) begin
        rsp_valid[i]             = 1'b1;
        rsp_rdata[i*DW +: DW]    = q_a;
      end else if (rst_n && tag_b.valid && (tag_b.id == 3'(i))) begin
        rsp_valid[i]             = 1'b1;
        rsp_rdata[i*DW +: DW]    = q_b;
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Directed bench for ram_dp_arbiter with a behavioural registered-read RAM.
module tb_ram_dp_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 6;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ*DW-1:0] rsp_rdata;
  logic [7:0]         conflict_cnt;
  logic [AW-1:0]      addr_a, addr_b;
  logic [DW-1:0]      data_a, data_b, q_a, q_b;
  logic               we_a, we_b;

  int n_checks = 0;
  int n_pass   = 0;
  int gcnt [NREQ];
  logic [NREQ-1:0] exp_rdy;

  logic [DW-1:0] mem [64];

  ram_dp_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .conflict_cnt (conflict_cnt),
    .addr_a       (addr_a),
    .data_a       (data_a),
    .we_a         (we_a),
    .addr_b       (addr_b),
    .data_b       (data_b),
    .we_b         (we_b),
    .q_a          (q_a),
    .q_b          (q_b)
  );

  // Clock and reset-time init.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Dual-port RAM model: registered read, write visible on the next read.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    q_a = '0;
    q_b = '0;
  end

  always @(posedge clk) begin
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
    if (we_a) mem[addr_a] <= data_a;
    if (we_b) mem[addr_b] <= data_b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. Reset with every requester asking to write.
    rst_n     = 1'b0;
    req_valid = '1;
    req_we    = '1;
    req_addr  = '0;
    req_wdata = '1;
    next_cycle();
    next_cycle();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_we_a", 32'(we_a), 32'h0);
    check("rst_we_b", 32'(we_b), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_cnt", 32'(conflict_cnt), 32'h0);
    rst_n = 1'b1;

    // 2. Parallel writes, then parallel reads.
    clear_reqs();
    set_req(0, 1'b1, 6'h01, 8'h33);
    set_req(1, 1'b1, 6'h02, 8'h44);
    @(negedge clk);
    check("pw_ready", 32'(req_ready), 32'h3);
    check("pw_port_a", {we_a, 2'b0, addr_a, data_a}, {1'b1, 2'b0, 6'h01, 8'h33});
    check("pw_port_b", {we_b, 2'b0, addr_b, data_b}, {1'b1, 2'b0, 6'h02, 8'h44});
    next_cycle();
    clear_reqs();
    set_req(2, 1'b0, 6'h01, 8'h00);
    set_req(3, 1'b0, 6'h02, 8'h00);
    @(negedge clk);
    check("pr_ready", 32'(req_ready), 32'hC);
    check("pr_we", {30'b0, we_a, we_b}, 32'h0);
    next_cycle();
    clear_reqs();
    check("pr_rsp_valid", 32'(rsp_valid), 32'hC);
    check("pr_rdata", 32'(rsp_rdata), 32'h4433_0000);

    // 3. Write/read hazard on the same address.
    set_req(0, 1'b1, 6'h03, 8'h55);
    set_req(1, 1'b0, 6'h03, 8'h00);
    @(negedge clk);
    check("hz_ready", 32'(req_ready), 32'h1);
    check("hz_port_b_idle", {we_b, 2'b0, addr_b, data_b}, 32'h0);
    next_cycle();
    check("hz_cnt", 32'(conflict_cnt), 32'h1);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("hz_retry_ready", 32'(req_ready), 32'h2);
    check("hz_retry_addr_a", {we_a, 1'b0, addr_a}, {1'b0, 1'b0, 6'h03});
    next_cycle();
    clear_reqs();
    check("hz_rsp_valid", 32'(rsp_valid), 32'h2);
    check("hz_rdata1", 32'(rsp_rdata[15:8]), 32'h55);

    // 5. Two reads of the same address are both granted (rr_ptr now 2).
    set_req(2, 1'b0, 6'h01, 8'h00);
    set_req(3, 1'b0, 6'h01, 8'h00);
    @(negedge clk);
    check("rr_ready", 32'(req_ready), 32'hC);
    next_cycle();
    clear_reqs();
    check("rr_rsp_valid", 32'(rsp_valid), 32'hC);
    check("rr_rdata", 32'(rsp_rdata), 32'h3333_0000);
    check("rr_cnt", 32'(conflict_cnt), 32'h1);

    // 4. Fairness: continuous reads at distinct addresses from rr_ptr 0.
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 6'(16 + i), 8'h00);
    for (int c = 0; c < 20; c++) begin
      exp_rdy = (c % 2 == 0) ? 4'b0011 : 4'b1100;
      @(negedge clk);
      check("fair_ready", 32'(req_ready), 32'(exp_rdy));
      for (int i = 0; i < NREQ; i++) gcnt[i] += int'(req_ready[i]);
      next_cycle();
      check("fair_rsp_valid", 32'(rsp_valid), 32'(exp_rdy));
    end
    clear_reqs();
    for (int i = 0; i < NREQ; i++) check("fair_grants", 32'(gcnt[i]), 32'd10);

    // 6a. Counter saturation: write vs read on one address every cycle.
    set_req(0, 1'b1, 6'h05, 8'h77);
    set_req(1, 1'b0, 6'h05, 8'h00);
    for (int c = 0; c < 300; c++) next_cycle();
    check("sat_cnt", 32'(conflict_cnt), 32'hFF);
    clear_reqs();
    next_cycle();

    // 6b. Reset asserted in the cycle after a read grant.
    set_req(2, 1'b0, 6'h01, 8'h00);
    @(negedge clk);
    check("mr_ready", 32'(req_ready), 32'h4);
    next_cycle();
    clear_reqs();
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mr_rdata", 32'(rsp_rdata), 32'h0);
    next_cycle();
    check("mr_cnt", 32'(conflict_cnt), 32'h0);
    check("mr_rsp_after", 32'(rsp_valid), 32'h0);
    rst_n = 1'b1;
    next_cycle();
    check("post_rsp_valid", 32'(rsp_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
